// File: rtl/vanet_frame_pkg.sv
// Frame constants, error codes and fetch FSM encoding shared by the SRAM frame producers/consumers.
package vanet_frame_pkg;

    typedef enum logic [7:0] {
        CMD_TX = 8'h66,
        CMD_RX = 8'h77
    } frame_cmd_e;

    localparam logic [7:0] HDR_CMD     = CMD_TX;
    localparam logic [7:0] LEN_BIAS    = 8'd2;
    localparam logic [7:0] MAX_PAYLOAD = 8'd64;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_HDR     = 2'd1,
        ERR_LEN     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_HDR,
        ST_HUNT,
        ST_RD_LEN,
        ST_EMIT_LEN,
        ST_RD_DATA,
        ST_EMIT_HI,
        ST_EMIT_LO,
        ST_DONE
    } fetch_state_e;

endpackage

// File: rtl/tx_frame_fetch_if.sv
// SRAM FIFO pop port and TX byte stream bundles; master is the frame fetcher side.
interface sram_fifo_if;
    logic        sram_read;
    logic        sram_hint;
    logic [15:0] data_from_sram;
    logic        sram_empty;
    logic [10:0] sram_count;

    modport master (output sram_read, input sram_hint, data_from_sram, sram_empty, sram_count);
    modport slave  (input sram_read, output sram_hint, data_from_sram, sram_empty, sram_count);
endinterface

interface tx_stream_if;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_sof;
    logic       tx_eof;
    logic       tx_abort;

    modport master (output tx_byte, tx_valid, tx_sof, tx_eof, tx_abort, input tx_ready);
    modport slave  (input tx_byte, tx_valid, tx_sof, tx_eof, tx_abort, output tx_ready);
endinterface

// File: rtl/tx_frame_fetch_sram_rd_port.sv
// Single-outstanding SRAM pop requester with hint timeout.
// Latency: sram_read rises 1 cycle after req with a non-empty FIFO; word/word_vld are valid in the hint cycle.
// Backpressure: no request is raised while the FIFO is empty; sram_read holds until hint or timeout.
module sram_rd_port #(
    parameter logic [15:0] HINT_TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        sram_empty,
    input  logic        sram_hint,
    input  logic [15:0] data_from_sram,
    output logic        sram_read,
    output logic [15:0] word,
    output logic        word_vld,
    output logic        timeout
);

    logic [15:0] hint_cnt;

    // Hint is checked first so a hint landing on the final count still completes the read.
    assign word     = data_from_sram;
    assign word_vld = sram_read && sram_hint;
    assign timeout  = sram_read && !sram_hint && (hint_cnt == HINT_TIMEOUT - 16'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sram_read <= 1'b0;
            hint_cnt  <= 16'd0;
        end else if (sram_read) begin
            if (sram_hint || timeout) begin
                sram_read <= 1'b0;
            end
            hint_cnt <= hint_cnt + 16'd1;
        end else if (req && !sram_empty) begin
            sram_read <= 1'b1;
            hint_cnt  <= 16'd0;
        end
    end

endmodule

// File: rtl/tx_frame_fetch.sv
// Pops framed words from the SRAM FIFO, validates header/length and unpacks the payload to a byte stream.
// Latency: first stream byte 1 cycle after the length-word hint; payload byte 1 cycle after each data hint.
// Backpressure: tx_ready low holds the presented byte stable; SRAM reads stall while the FIFO is empty.
module tx_frame_fetch
    import vanet_frame_pkg::*;
#(
    parameter logic [15:0] HINT_TIMEOUT = 16'd50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    sram_fifo_if.master sram,
    tx_stream_if.master tx,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  err_code
);

    fetch_state_e state;
    logic [7:0]   rem;
    logic [7:0]   lo_byte;
    logic         rd_req;
    logic [15:0]  word;
    logic         word_vld;
    logic         rd_timeout;
    logic         hdr_hit;
    logic [7:0]   len_l;
    logic         len_bad;
    logic         accept;

    sram_rd_port #(
        .HINT_TIMEOUT (HINT_TIMEOUT)
    ) u_rd_port (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (rd_req),
        .sram_empty     (sram.sram_empty),
        .sram_hint      (sram.sram_hint),
        .data_from_sram (sram.data_from_sram),
        .sram_read      (sram.sram_read),
        .word           (word),
        .word_vld       (word_vld),
        .timeout        (rd_timeout)
    );

    assign rd_req  = state inside {ST_RD_HDR, ST_HUNT, ST_RD_LEN, ST_RD_DATA};
    assign hdr_hit = (word[15:8] == HDR_CMD);
    assign len_l   = word[7:0] - LEN_BIAS;
    assign len_bad = (word[15:8] != 8'h00) || (word[7:0] < LEN_BIAS) ||
                     (len_l == 8'd0) || (len_l > MAX_PAYLOAD);
    assign accept  = tx.tx_valid && tx.tx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rem         <= 8'd0;
            lo_byte     <= 8'd0;
            tx.tx_byte  <= 8'd0;
            tx.tx_valid <= 1'b0;
            tx.tx_sof   <= 1'b0;
            tx.tx_eof   <= 1'b0;
            tx.tx_abort <= 1'b0;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            tx.tx_abort <= 1'b0;
            if (rd_timeout) begin
                state       <= ST_IDLE;
                frame_err   <= 1'b1;
                err_code    <= ERR_TIMEOUT;
                tx.tx_abort <= frame_busy;
                frame_busy  <= 1'b0;
                tx.tx_valid <= 1'b0;
                tx.tx_sof   <= 1'b0;
                tx.tx_eof   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (enable && (sram.sram_count >= 11'd2)) begin
                            state      <= ST_RD_HDR;
                            frame_busy <= 1'b1;
                        end
                    end
                    ST_RD_HDR: begin
                        if (word_vld) begin
                            if (hdr_hit) begin
                                state <= ST_RD_LEN;
                            end else begin
                                state     <= ST_HUNT;
                                frame_err <= 1'b1;
                                err_code  <= ERR_HDR;
                            end
                        end
                    end
                    ST_HUNT: begin
                        if (word_vld && hdr_hit) begin
                            state <= ST_RD_LEN;
                        end
                    end
                    ST_RD_LEN: begin
                        if (word_vld) begin
                            if (len_bad) begin
                                state     <= ST_HUNT;
                                frame_err <= 1'b1;
                                err_code  <= ERR_LEN;
                            end else begin
                                state       <= ST_EMIT_LEN;
                                rem         <= len_l;
                                tx.tx_byte  <= len_l;
                                tx.tx_sof   <= 1'b1;
                                tx.tx_valid <= 1'b1;
                            end
                        end
                    end
                    ST_EMIT_LEN: begin
                        if (accept) begin
                            state       <= ST_RD_DATA;
                            tx.tx_valid <= 1'b0;
                            tx.tx_sof   <= 1'b0;
                        end
                    end
                    ST_RD_DATA: begin
                        if (word_vld) begin
                            state       <= ST_EMIT_HI;
                            tx.tx_byte  <= word[15:8];
                            lo_byte     <= word[7:0];
                            tx.tx_valid <= 1'b1;
                            tx.tx_eof   <= (rem == 8'd1);
                        end
                    end
                    // eof is set when a byte is loaded, from the count it will leave behind.
                    ST_EMIT_HI: begin
                        if (accept) begin
                            rem <= rem - 8'd1;
                            if (rem == 8'd1) begin
                                state       <= ST_DONE;
                                tx.tx_valid <= 1'b0;
                                tx.tx_eof   <= 1'b0;
                            end else begin
                                state      <= ST_EMIT_LO;
                                tx.tx_byte <= lo_byte;
                                tx.tx_eof  <= (rem == 8'd2);
                            end
                        end
                    end
                    ST_EMIT_LO: begin
                        if (accept) begin
                            rem         <= rem - 8'd1;
                            tx.tx_valid <= 1'b0;
                            tx.tx_eof   <= 1'b0;
                            state       <= (rem == 8'd1) ? ST_DONE : ST_RD_DATA;
                        end
                    end
                    ST_DONE: begin
                        frame_done <= 1'b1;
                        frame_busy <= 1'b0;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_fetch.sv
// Directed bench for tx_frame_fetch: SRAM FIFO responder, byte scoreboard and pulse counters.
module tb_tx_frame_fetch;

    localparam int HINT_TIMEOUT = 50000;
    localparam int HINT_LAT     = 2;

    typedef logic [7:0]  byte_q_t [$];
    typedef logic [10:0] exp_t;

    logic clk;
    logic reset_n;
    logic enable;
    logic frame_busy, frame_done, frame_err;
    logic [1:0] err_code;

    sram_fifo_if sram ();
    tx_stream_if tx ();

    tx_frame_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .sram       (sram),
        .tx         (tx),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .err_code   (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] sram_q [$];
    exp_t exp_q [$];
    int pop_cnt = 0;
    int stall_at_pop = -1;
    int done_cnt = 0;
    int err_cnt = 0;
    int abort_cnt = 0;
    int stall_cnt = 0;
    logic [1:0] last_code = 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM FIFO responder: hint HINT_LAT cycles into a request, optionally withheld at one pop index.
    initial begin
        int lat;
        lat = 0;
        sram.sram_hint = 1'b0;
        sram.data_from_sram = 16'h0000;
        sram.sram_empty = 1'b1;
        sram.sram_count = 11'd0;
        forever begin
            @(posedge clk);
            #1;
            sram.sram_hint = 1'b0;
            if (sram.sram_read && (pop_cnt != stall_at_pop)) begin
                lat++;
                if (lat >= HINT_LAT && sram_q.size() > 0) begin
                    sram.sram_hint = 1'b1;
                    sram.data_from_sram = sram_q.pop_front();
                    pop_cnt++;
                    lat = 0;
                end
            end else begin
                lat = 0;
            end
            sram.sram_empty = (sram_q.size() == 0);
            sram.sram_count = 11'(sram_q.size());
        end
    end

    // Stream monitor: scoreboard on accept, stability while stalled, pulse counting.
    initial begin
        logic stalled;
        logic [10:0] held, got, want;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled)
                    check("held_stream", {tx.tx_valid, tx.tx_sof, tx.tx_eof, tx.tx_byte}, held);
                if (tx.tx_valid && tx.tx_ready) begin
                    got = {1'b1, tx.tx_sof, tx.tx_eof, tx.tx_byte};
                    if (exp_q.size() > 0) want = exp_q.pop_front();
                    else want = 11'h000;
                    check("stream_byte", got, want);
                end
                stalled = tx.tx_valid && !tx.tx_ready;
                held = {1'b1, tx.tx_sof, tx.tx_eof, tx.tx_byte};
                if (stalled) stall_cnt++;
                if (frame_done) done_cnt++;
                if (tx.tx_abort) abort_cnt++;
                if (frame_err) begin
                    err_cnt++;
                    last_code = err_code;
                end
            end
        end
    end

    task automatic push_frame(input byte_q_t pl, input int n_exp);
        int len;
        len = pl.size();
        sram_q.push_back(16'h66A5);
        sram_q.push_back({8'h00, 8'(len + 2)});
        for (int i = 0; i < len; i += 2)
            sram_q.push_back({pl[i], (i + 1 < len) ? pl[i + 1] : 8'hFF});
        exp_q.push_back({1'b1, 1'b1, 1'b0, 8'(len)});
        for (int i = 0; i < n_exp; i++)
            exp_q.push_back({1'b1, 1'b0, (i == len - 1), pl[i]});
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, done_cnt, target);
    endtask

    task automatic wait_byte(input logic [7:0] b, input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(tx.tx_valid && tx.tx_byte == b) && n < budget);
        check(tag, tx.tx_valid && tx.tx_byte == b, 1);
    endtask

    initial begin
        byte_q_t pl;
        int n;
        reset_n = 1'b0;
        enable = 1'b0;
        tx.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {sram.sram_read, tx.tx_valid, tx.tx_sof, tx.tx_eof, tx.tx_abort,
                                frame_busy, frame_done, frame_err}, 8'h00);
        check("reset_err_code", err_code, 2'd0);
        check("reset_tx_byte", tx.tx_byte, 8'h00);
        reset_n = 1'b1;
        enable = 1'b1;

        // L=5, odd: padding byte FF must never appear
        pop_cnt = 0;
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        push_frame(pl, 5);
        wait_done(1, 300, "l5_done");
        repeat (3) @(posedge clk);
        #1;
        check("l5_reads", pop_cnt, 5);
        check("l5_exp_drained", exp_q.size(), 0);
        check("l5_busy_clear", frame_busy, 1'b0);
        check("l5_no_err", err_cnt, 0);

        // L=4 with a 7-cycle sink stall on byte 02
        stall_cnt = 0;
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        push_frame(pl, 4);
        wait_byte(8'h02, 300, "l4_byte02_seen");
        tx.tx_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("l4_busy_mid", frame_busy, 1'b1);
        tx.tx_ready = 1'b1;
        wait_done(2, 300, "l4_done");
        check("l4_stall_cycles", stall_cnt, 7);
        check("l4_exp_drained", exp_q.size(), 0);

        // bad header, junk word in HUNT, then L=2
        sram_q.push_back(16'h5500);
        sram_q.push_back(16'h1234);
        pl = '{8'hAA, 8'hBB};
        push_frame(pl, 2);
        wait_done(3, 300, "hdr_done");
        check("hdr_err_cnt", err_cnt, 1);
        check("hdr_err_code", last_code, 2'd1);
        check("hdr_err_hold", err_code, 2'd1);
        check("hdr_exp_drained", exp_q.size(), 0);

        // length errors: L below bias, L=65, L=0; then L=1
        sram_q.push_back(16'h6600);
        sram_q.push_back(16'h0001);
        sram_q.push_back(16'h6600);
        sram_q.push_back(16'h0043);
        sram_q.push_back(16'h6600);
        sram_q.push_back(16'h0002);
        pl = '{8'h7F};
        push_frame(pl, 1);
        wait_done(4, 400, "len_done");
        check("len_err_cnt", err_cnt, 4);
        check("len_err_code", last_code, 2'd2);
        check("len_exp_drained", exp_q.size(), 0);

        // maximum payload accepted
        pl = {};
        for (int i = 0; i < 64; i++) pl.push_back(8'(8'h40 + i));
        push_frame(pl, 64);
        wait_done(5, 2000, "max_done");
        check("max_exp_drained", exp_q.size(), 0);
        check("max_no_err", err_cnt, 4);

        // hint withheld on the second payload word of an L=6 frame
        pop_cnt = 0;
        stall_at_pop = 3;
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        push_frame(pl, 2);
        wait_byte(8'h06, 300, "to_frame_start");
        enable = 1'b0;
        n = 0;
        while (abort_cnt == 0 && n < HINT_TIMEOUT + 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("to_abort_cnt", abort_cnt, 1);
        check("to_not_early", n >= HINT_TIMEOUT, 1);
        check("to_err_code", err_code, 2'd3);
        check("to_err_cnt", err_cnt, 5);
        check("to_read_dropped", sram.sram_read, 1'b0);
        check("to_busy_clear", frame_busy, 1'b0);
        check("to_exp_drained", exp_q.size(), 0);
        stall_at_pop = -1;
        sram_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("to_done_unchanged", done_cnt, 5);
        enable = 1'b1;

        // reset asserted while the low byte waits on the sink
        pl = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        push_frame(pl, 1);
        wait_byte(8'h0B, 300, "rst_lo_seen");
        tx.tx_ready = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", {sram.sram_read, tx.tx_valid, tx.tx_sof, tx.tx_eof, tx.tx_abort,
                                  frame_busy, frame_done, frame_err}, 8'h00);
        check("rst_mid_err_code", err_code, 2'd0);
        check("rst_exp_drained", exp_q.size(), 0);
        sram_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        tx.tx_ready = 1'b1;
        check("rst_no_abort", abort_cnt, 1);
        pl = '{8'h11, 8'h22, 8'h33};
        push_frame(pl, 3);
        wait_done(6, 300, "post_rst_done");
        check("post_rst_exp_drained", exp_q.size(), 0);
        check("post_rst_err_cnt", err_cnt, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
